// File: rtl/barrel_pkg.sv
// Shared frame geometry, bus widths and pipeline tag types for the barrel pixel fetch path.
package barrel_pkg;
  localparam int H_ACTIVE_DFLT = 1080;
  localparam int V_ACTIVE_DFLT = 960;
  localparam int ADDR_W        = 20;
  localparam int PIX_W         = 12;
  localparam int COORD_W       = 12;

  typedef struct packed {
    logic               vld;
    logic               oob;
    logic [ADDR_W-1:0]  row_base;
    logic [COORD_W-1:0] x;
  } stage_a_t;
endpackage

// File: rtl/barrel_pixel_fetch_if.sv
// Output pixel stream (AXI-stream style valid/ready with start-of-frame and end-of-line marks).
interface barrel_pixel_fetch_if;
  import barrel_pkg::*;

  logic [PIX_W-1:0] m_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic             m_tuser;
  logic             m_tlast;

  modport master (output m_tdata, m_tvalid, m_tuser, m_tlast, input m_tready);
  modport slave  (input m_tdata, m_tvalid, m_tuser, m_tlast, output m_tready);
endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: head visible on rd_dat while rd_vld; write and pop may share an edge.
// Writes into a full FIFO are only taken when the same edge pops.
module sync_fifo_fwft #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_dat,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_dat,
  output logic                       rd_vld,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign rd_vld = (count != '0);
  assign rd_dat = mem[rd_ptr];
  assign do_rd  = rd_en && rd_vld;
  assign do_wr  = wr_en && ((count != CNT_W'(DEPTH)) || do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      if (do_wr && !do_rd)      count <= count + CNT_W'(1);
      else if (!do_wr && do_rd) count <= count - CNT_W'(1);
    end
  end
endmodule

// File: rtl/barrel_pixel_fetch.sv
// Turns source (x,y) requests into frame-BRAM reads and streams pixels out in request order.
// Request to FIFO write is 2+MEM_LAT edges; mem_ready throttles upstream, overflowing requests are dropped.
module barrel_pixel_fetch
  import barrel_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DFLT,
  parameter int V_ACTIVE   = V_ACTIVE_DFLT,
  parameter int MEM_LAT    = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [COORD_W-1:0]   xIn,
  input  logic [COORD_W-1:0]   yIn,
  input  logic                 addr_vld,
  output logic                 mem_ready,
  output logic [ADDR_W-1:0]    bram_addr,
  output logic                 bram_en,
  input  logic [PIX_W-1:0]     bram_dout,
  barrel_pixel_fetch_if.master m_axis,
  output logic                 err_overflow
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TOT_W = CNT_W + 1;

  stage_a_t           sa;
  logic               vld_b;
  logic               oob_b;
  logic [ADDR_W-1:0]  addr_b;
  logic [MEM_LAT-1:0] dl_vld;
  logic [MEM_LAT-1:0] dl_oob;
  logic [CNT_W-1:0]   inflight;
  logic [CNT_W-1:0]   fifo_count;
  logic [TOT_W-1:0]   total;
  logic               accept;
  logic               fifo_wr;
  logic               fifo_rd;
  logic               fifo_vld;
  logic               out_vld;
  logic               err_q;
  logic [PIX_W-1:0]   fifo_wdat;
  logic [PIX_W-1:0]   fifo_rdat;
  logic [COORD_W-1:0] col;
  logic [COORD_W-1:0] row;

  // Everything accepted but not yet popped occupies a FIFO slot, so the FIFO can never overflow.
  assign total     = TOT_W'(fifo_count) + TOT_W'(inflight);
  assign accept    = addr_vld && (total != TOT_W'(FIFO_DEPTH));
  assign mem_ready = !reset && (total <= TOT_W'(FIFO_DEPTH - 2));

  always_ff @(posedge clk) begin
    if (reset) begin
      sa <= '0;
    end else begin
      sa.vld      <= accept;
      sa.oob      <= (xIn >= COORD_W'(H_ACTIVE)) || (yIn >= COORD_W'(V_ACTIVE));
      sa.row_base <= ADDR_W'(yIn * H_ACTIVE);
      sa.x        <= xIn;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_b  <= 1'b0;
      oob_b  <= 1'b0;
      addr_b <= '0;
    end else begin
      vld_b <= sa.vld;
      oob_b <= sa.oob;
      if (sa.vld && !sa.oob) addr_b <= sa.row_base + ADDR_W'(sa.x);
    end
  end

  assign bram_en   = vld_b && !oob_b && !reset;
  assign bram_addr = reset ? '0 : addr_b;

  // Tags ride alongside the BRAM read so returning data lines up with its request.
  always_ff @(posedge clk) begin
    if (reset) begin
      dl_vld <= '0;
      dl_oob <= '0;
    end else begin
      dl_vld[0] <= vld_b;
      dl_oob[0] <= oob_b;
      for (int i = 1; i < MEM_LAT; i++) begin
        dl_vld[i] <= dl_vld[i-1];
        dl_oob[i] <= dl_oob[i-1];
      end
    end
  end

  assign fifo_wr   = dl_vld[MEM_LAT-1];
  assign fifo_wdat = dl_oob[MEM_LAT-1] ? '0 : bram_dout;

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept && !fifo_wr)      inflight <= inflight + CNT_W'(1);
      else if (!accept && fifo_wr) inflight <= inflight - CNT_W'(1);
      if (addr_vld && !accept) err_q <= 1'b1;
    end
  end

  assign err_overflow = err_q && !reset;

  sync_fifo_fwft #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (fifo_wr),
    .wr_dat (fifo_wdat),
    .rd_en  (fifo_rd),
    .rd_dat (fifo_rdat),
    .rd_vld (fifo_vld),
    .count  (fifo_count)
  );

  assign out_vld         = fifo_vld && !reset;
  assign fifo_rd         = out_vld && m_axis.m_tready;
  assign m_axis.m_tvalid = out_vld;
  assign m_axis.m_tdata  = out_vld ? fifo_rdat : '0;
  assign m_axis.m_tuser  = out_vld && (col == '0) && (row == '0);
  assign m_axis.m_tlast  = out_vld && (col == COORD_W'(H_ACTIVE - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (fifo_rd) begin
      if (col == COORD_W'(H_ACTIVE - 1)) begin
        col <= '0;
        row <= (row == COORD_W'(V_ACTIVE - 1)) ? '0 : row + COORD_W'(1);
      end else begin
        col <= col + COORD_W'(1);
      end
    end
  end
endmodule
